// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard blocks.
// Contents: Set-2 prefix/control byte constants, the prefix FSM state
// encoding, and the geometry of the seven-segment digit word.
package ps2_pkg;

    localparam logic [7:0] BRK_CODE  = 8'hF0;
    localparam logic [7:0] EXT_CODE  = 8'hE0;
    localparam logic [7:0] BKSP_CODE = 8'h66;
    localparam logic [7:0] ESC_CODE  = 8'h76;

    localparam int DIGIT_W    = 5;
    localparam int NUM_DIGITS = 4;
    localparam int BUF_W      = DIGIT_W * NUM_DIGITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_state_t;

endpackage

// File: rtl/ps2_key_display_ctrl_if.sv
// Byte stream from the PS/2 receiver into the key display controller.
// Signals: rx_done_tick - one-cycle strobe, rx_data valid in the same cycle
//          rx_data      - received scan-code byte
// Modports: master = byte source (receiver), slave = byte sink (controller).
interface ps2_key_display_ctrl_if;

    logic       rx_done_tick;
    logic [7:0] rx_data;

    modport master (output rx_done_tick, output rx_data);
    modport slave  (input  rx_done_tick, input  rx_data);

endinterface

// File: rtl/ps2_hex_decode.sv
// Combinational Set-2 scan code to hex digit decoder.
// Ports: code   - scan-code byte
//        is_hex - 1 when code is one of the 0-9 / A-F keys
//        hex    - digit value, 0 when is_hex is 0
module ps2_hex_decode (
    input  logic [7:0] code,
    output logic       is_hex,
    output logic [3:0] hex
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        is_hex = 1'b1;
        hex    = 4'h0;
        unique case (code)
            8'h45: hex = 4'h0;
            8'h16: hex = 4'h1;
            8'h1E: hex = 4'h2;
            8'h26: hex = 4'h3;
            8'h25: hex = 4'h4;
            8'h2E: hex = 4'h5;
            8'h36: hex = 4'h6;
            8'h3D: hex = 4'h7;
            8'h3E: hex = 4'h8;
            8'h46: hex = 4'h9;
            8'h1C: hex = 4'hA;
            8'h32: hex = 4'hB;
            8'h21: hex = 4'hC;
            8'h23: hex = 4'hD;
            8'h24: hex = 4'hE;
            8'h2B: hex = 4'hF;
            default: is_hex = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_key_display_ctrl.sv
// Turns PS/2 Set-2 scan-code bytes into a 4-digit hex entry buffer for the
// seven-segment driver. Handles F0 (break) and E0 (extended) prefixes with a
// timeout, optional typematic-repeat suppression, Backspace and Esc.
// Ports: clk, rst      - clock, synchronous active-high reset
//        rx            - byte stream from the receiver (slave modport)
//        sevenOut      - digit i in [5i+4:5i] as {en, hex}; digit 0 rightmost
//        key_valid     - one-cycle pulse when a key action hits the buffer
//        key_hex       - value of the last accepted hex key
//        digit_cnt     - number of enabled digits, 0..4
module ps2_key_display_ctrl
    import ps2_pkg::*;
#(
    parameter logic [23:0] PREFIX_TIMEOUT  = 24'd5_000_000,
    parameter bit          REPEAT_SUPPRESS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    ps2_key_display_ctrl_if.slave rx,
    output logic [BUF_W-1:0]      sevenOut,
    output logic                  key_valid,
    output logic [3:0]            key_hex,
    output logic [2:0]            digit_cnt
);

    ps2_state_t  state, state_next;
    logic [23:0] tmo_cnt;
    logic [7:0]  held;
    logic        tick;
    logic        timeout;
    logic        make_evt;
    logic        accept;
    logic        is_hex;
    logic [3:0]  hex;

    assign tick = rx.rx_done_tick;

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign timeout = (state != IDLE) && !tick && (tmo_cnt == PREFIX_TIMEOUT - 24'd1);

    ps2_hex_decode u_hex_decode (
        .code   (rx.rx_data),
        .is_hex (is_hex),
        .hex    (hex)
    );

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (tick && rx.rx_data == BRK_CODE)      state_next = BRK;
                else if (tick && rx.rx_data == EXT_CODE) state_next = EXT;
            end
            BRK, EXT_BRK: begin
                if (tick || timeout) state_next = IDLE;
            end
            EXT: begin
                if (tick && rx.rx_data == BRK_CODE) state_next = EXT_BRK;
                else if (tick || timeout)           state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode: which byte actions apply this cycle
    always_comb begin
        make_evt = (state == IDLE) && tick &&
                   (rx.rx_data != BRK_CODE) && (rx.rx_data != EXT_CODE);
        accept   = make_evt && !(REPEAT_SUPPRESS && (rx.rx_data == held));
    end

    // Prefix timeout counter: cleared on every byte and whenever the FSM
    // is (or is about to be) idle, so it measures silence within a prefix.
    always_ff @(posedge clk) begin
        if (rst || tick || state_next == IDLE) tmo_cnt <= '0;
        else                                   tmo_cnt <= tmo_cnt + 24'd1;
    end

    // Held key and entry buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            held      <= 8'h00;
            sevenOut  <= '0;
            key_valid <= 1'b0;
            key_hex   <= 4'h0;
            digit_cnt <= 3'd0;
        end else begin
            key_valid <= 1'b0;
            if (state == BRK && tick && rx.rx_data == held)
                held <= 8'h00;
            if (accept) begin
                held <= rx.rx_data;
                if (is_hex) begin
                    sevenOut  <= {sevenOut[BUF_W-DIGIT_W-1:0], 1'b1, hex};
                    key_hex   <= hex;
                    key_valid <= 1'b1;
                    if (digit_cnt != 3'(NUM_DIGITS)) digit_cnt <= digit_cnt + 3'd1;
                end else if (rx.rx_data == BKSP_CODE) begin
                    sevenOut  <= {{DIGIT_W{1'b0}}, sevenOut[BUF_W-1:DIGIT_W]};
                    key_valid <= 1'b1;
                    if (digit_cnt != 3'd0) digit_cnt <= digit_cnt - 3'd1;
                end else if (rx.rx_data == ESC_CODE) begin
                    sevenOut  <= '0;
                    digit_cnt <= 3'd0;
                    key_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_display_ctrl.sv
// Directed testbench for ps2_key_display_ctrl. Two instances share one byte
// stream: dut_a suppresses typematic repeats, dut_b accepts every make code.
// Both use a short prefix timeout of 16 cycles.
module tb_ps2_key_display_ctrl;
    import ps2_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [19:0] seven_a, seven_b;
    logic        kv_a, kv_b;
    logic [3:0]  hex_a, hex_b;
    logic [2:0]  cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;

    ps2_key_display_ctrl_if rx_if ();

    ps2_key_display_ctrl #(.PREFIX_TIMEOUT(24'd16), .REPEAT_SUPPRESS(1'b1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx_if.slave),
        .sevenOut  (seven_a),
        .key_valid (kv_a),
        .key_hex   (hex_a),
        .digit_cnt (cnt_a)
    );

    ps2_key_display_ctrl #(.PREFIX_TIMEOUT(24'd16), .REPEAT_SUPPRESS(1'b0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx_if.slave),
        .sevenOut  (seven_b),
        .key_valid (kv_b),
        .key_hex   (hex_b),
        .digit_cnt (cnt_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one byte for one cycle; on return the edge after the tick has
    // passed, so outputs show the 1-cycle-latency result.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_if.rx_done_tick = 1'b1;
        rx_if.rx_data      = b;
        @(negedge clk);
        rx_if.rx_done_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] seq5 [15] = '{8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E,
                              8'h26, 8'hF0, 8'h26, 8'h25, 8'hF0, 8'h25,
                              8'h2E, 8'hF0, 8'h2E};

    initial begin
        rx_if.rx_done_tick = 1'b0;
        rx_if.rx_data      = 8'h00;
        idle_cycles(2);
        rst = 1'b0;
        // Reset state after the initial reset
        check("rst_seven", 32'(seven_a), 32'h0);
        check("rst_kv",    32'(kv_a),    32'h0);
        check("rst_hex",   32'(hex_a),   32'h0);
        check("rst_cnt",   32'(cnt_a),   32'h0);
        check("rst_state", 32'(dut_a.state), 32'(IDLE));

        // Two keys with breaks: digits off,off,1,2
        send(8'h16);
        check("t1_kv1",  32'(kv_a),    32'h1);
        check("t1_hex1", 32'(hex_a),   32'h1);
        check("t1_sev1", 32'(seven_a), 32'h00011);
        idle_cycles(1);
        check("t1_kv_pulse_end", 32'(kv_a), 32'h0);
        send(8'hF0);
        check("t1_kv_f0", 32'(kv_a), 32'h0);
        send(8'h16);
        check("t1_kv_brk", 32'(kv_a), 32'h0);
        send(8'h1E);
        check("t1_kv2",  32'(kv_a),    32'h1);
        check("t1_hex2", 32'(hex_a),   32'h2);
        send(8'hF0);
        send(8'h1E);
        check("t1_sev",  32'(seven_a), 32'h00232);
        check("t1_cnt",  32'(cnt_a),   32'h2);

        // Typematic repeats
        do_reset();
        send(8'h16);
        send(8'h16);
        check("t2_kv_rep_a", 32'(kv_a), 32'h0);
        check("t2_kv_rep_b", 32'(kv_b), 32'h1);
        send(8'h16);
        send(8'hF0);
        send(8'h16);
        check("t2_cnt_a", 32'(cnt_a),   32'h1);
        check("t2_sev_a", 32'(seven_a), 32'h00011);
        check("t2_cnt_b", 32'(cnt_b),   32'h3);
        check("t2_sev_b", 32'(seven_b), {12'h0, 5'h11, 5'h11, 5'h11});

        // Five digits overflow, then Backspace and Esc
        do_reset();
        for (int i = 0; i < 15; i++) send(seq5[i]);
        check("t3_sev_full", 32'(seven_a), 32'({5'h12, 5'h13, 5'h14, 5'h15}));
        check("t3_cnt_sat",  32'(cnt_a),   32'h4);
        send(8'h66);
        check("t3_kv_bksp",  32'(kv_a),    32'h1);
        check("t3_sev_bksp", 32'(seven_a), 32'({5'h00, 5'h12, 5'h13, 5'h14}));
        check("t3_cnt_bksp", 32'(cnt_a),   32'h3);
        check("t3_hex_keep", 32'(hex_a),   32'h5);
        send(8'h76);
        check("t3_kv_esc",   32'(kv_a),    32'h1);
        check("t3_sev_esc",  32'(seven_a), 32'h0);
        check("t3_cnt_esc",  32'(cnt_a),   32'h0);
        // Backspace on an empty buffer still pulses key_valid
        send(8'h66);
        check("t3_kv_bksp_empty",  32'(kv_a),    32'h1);
        check("t3_sev_bksp_empty", 32'(seven_a), 32'h0);
        check("t3_cnt_bksp_empty", 32'(cnt_a),   32'h0);
        // Unmapped code: no effect, no pulse
        send(8'h29);
        check("t3_kv_other", 32'(kv_a), 32'h0);

        // Extended Up make and break are ignored
        send(8'h45);
        check("t4_sev_pre", 32'(seven_a), 32'h00010);
        send(8'hE0);
        check("t4_state_ext", 32'(dut_a.state), 32'(EXT));
        send(8'h75);
        check("t4_kv_ext", 32'(kv_a), 32'h0);
        send(8'hE0);
        send(8'hF0);
        check("t4_state_extbrk", 32'(dut_a.state), 32'(EXT_BRK));
        send(8'h75);
        check("t4_kv_extbrk", 32'(kv_a),    32'h0);
        check("t4_sev",       32'(seven_a), 32'h00010);
        check("t4_state",     32'(dut_a.state), 32'(IDLE));

        // Prefix timeout: a byte well inside the window is still a break,
        // after the window expires the next byte is a fresh make.
        do_reset();
        send(8'hF0);
        idle_cycles(10);
        check("t5_state_brk", 32'(dut_a.state), 32'(BRK));
        send(8'h45);
        check("t5_kv_in_window", 32'(kv_a),    32'h0);
        check("t5_sev_in_window", 32'(seven_a), 32'h0);
        send(8'hF0);
        idle_cycles(20);
        check("t5_state_tmo", 32'(dut_a.state), 32'(IDLE));
        send(8'h45);
        check("t5_kv_after", 32'(kv_a),    32'h1);
        check("t5_sev_after", 32'(seven_a), 32'h00010);
        check("t5_cnt_after", 32'(cnt_a),   32'h1);

        // Reset in the middle of a break sequence
        send(8'hF0);
        do_reset();
        check("t6_rst_sev",   32'(seven_a), 32'h0);
        check("t6_rst_cnt",   32'(cnt_a),   32'h0);
        check("t6_rst_hex",   32'(hex_a),   32'h0);
        check("t6_rst_state", 32'(dut_a.state), 32'(IDLE));
        send(8'h1E);
        check("t6_kv",  32'(kv_a),    32'h1);
        check("t6_sev", 32'(seven_a), 32'h00012);
        check("t6_cnt", 32'(cnt_a),   32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
